fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. Holds the program counter and drives the word address of the combinational `instruction_memory` (8-bit `addr` in, `DATA_WIDTH` instruction out). It buffers fetched instructions with their PCs in a small FIFO. It presents them to decode through a valid/ready handshake and accepts branch/jump redirects that flush the buffer.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation plus a small prefetch FIFO of {pc, inst} feeding decode over valid/ready.
module fetch_unit #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_en,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic [DATA_WIDTH-1:0]        imem_inst,
    output logic                         if_valid,
    output logic [DATA_WIDTH-1:0]        if_inst,
    output logic [31:0]                  if_pc,
    input  logic                         id_ready,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]           pc_q, pc_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           pc_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];
    logic                  push, pop;

    // Redirect wins over everything; a pop frees the slot a full-FIFO push needs.
    assign pop  = if_valid && id_ready && !redirect_valid;
    assign push = fetch_en && !redirect_valid && ((cnt_q < CW'(DEPTH)) || pop);

    assign imem_addr = pc_q[ADDR_WIDTH+1:2];
    assign if_valid  = cnt_q != '0;
    assign if_pc     = pc_mem_q[rd_q];
    assign if_inst   = inst_mem_q[rd_q];
    assign occupancy = cnt_q;

    // Next-state for pc, pointers and count; redirect flushes and restarts at the aligned target.
    always_comb begin
        pc_d  = pc_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redirect_valid) begin
            pc_d  = redirect_pc & ~32'h3;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            pc_d  = push ? pc_q + 32'd4 : pc_q;
            wr_d  = push ? wr_q + PW'(1) : wr_q;
            rd_d  = pop ? rd_q + PW'(1) : rd_q;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // FIFO storage; cleared on reset so an empty head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_q]   <= pc_q;
            inst_mem_q[wr_q] <= imem_inst;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven vectors plus a {pc, inst} scoreboard for fetch_unit.
module tb_fetch_unit;
    localparam logic [31:0] I0 = 32'h0050_0093, I1 = 32'h00a0_0113,
                            I2 = 32'h0020_81b3, I3 = 32'h0000_0013,
                            IFF = 32'h0BAD_00FF;

    logic        clk = 0, rst_n = 0, fetch_en = 0, id_ready = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = 0, imem_inst, if_inst, if_pc;
    logic [7:0]  imem_addr;
    logic        if_valid;
    logic [1:0]  occupancy;
    logic [31:0] mem [256];

    typedef struct {
        logic        fe, rdy, rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc, einst;
        logic [1:0]  eocc;
        logic [7:0]  eaddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc, inst;
    } ent_t;

    vec_t        tbl [27];
    ent_t        sb [$];
    logic [31:0] mpc;
    int          n_cmp = 0, n_err = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_inst(imem_inst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .occupancy(occupancy)
    );

    assign imem_inst = mem[imem_addr];

    always #5 clk = ~clk;

    function automatic vec_t v(logic fe, logic rdy, logic rv, logic [31:0] rpc, logic ev,
                               logic [31:0] epc, logic [31:0] einst, logic [1:0] eocc, logic [7:0] eaddr);
        vec_t r;
        r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.ev = ev;
        r.epc = epc; r.einst = einst; r.eocc = eocc; r.eaddr = eaddr;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Called just after a falling edge: check table row, drive inputs, update scoreboard, advance one cycle.
    task automatic step(int idx, vec_t r);
        ent_t e;
        int   pre;
        logic mpop;
        chk("valid", idx, {31'd0, if_valid}, {31'd0, r.ev});
        chk("occ", idx, {30'd0, occupancy}, {30'd0, r.eocc});
        chk("addr", idx, {24'd0, imem_addr}, {24'd0, r.eaddr});
        if (r.ev) begin
            chk("head_pc", idx, if_pc, r.epc);
            chk("head_inst", idx, if_inst, r.einst);
        end
        fetch_en = r.fe; id_ready = r.rdy; redirect_valid = r.rv; redirect_pc = r.rpc;
        pre  = sb.size();
        mpop = pre != 0 && r.rdy && !r.rv;
        chk("sb_occ", idx, {30'd0, occupancy}, 32'(pre));
        chk("sb_addr", idx, {24'd0, imem_addr}, {24'd0, mpc[9:2]});
        if (mpop) begin
            e = sb.pop_front();
            chk("sb_pc", idx, if_pc, e.pc);
            chk("sb_inst", idx, if_inst, e.inst);
        end
        if (r.rv) begin
            sb.delete();
            mpc = r.rpc & ~32'h3;
        end else if (r.fe && (pre < 2 || mpop)) begin
            e.pc = mpc; e.inst = mem[mpc[9:2]];
            sb.push_back(e);
            mpc = mpc + 4;
        end
        @(negedge clk);
    endtask

    task automatic mid_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_valid", 99, {31'd0, if_valid}, 32'd0);
        chk("rst_occ", 99, {30'd0, occupancy}, 32'd0);
        chk("rst_addr", 99, {24'd0, imem_addr}, 32'd0);
        chk("rst_pc", 99, if_pc, 32'd0);
        chk("rst_inst", 99, if_inst, 32'd0);
        sb.delete();
        mpc = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0BAD_0000 | i;
        mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = I3;
        mpc = 0;
        tbl[0]  = v(1, 1, 0, 0,      0, 0,      0,   0, 8'h00);
        tbl[1]  = v(1, 1, 0, 0,      1, 0,      I0,  1, 8'h01);
        tbl[2]  = v(1, 1, 0, 0,      1, 4,      I1,  1, 8'h02);
        tbl[3]  = v(1, 1, 0, 0,      1, 8,      I2,  1, 8'h03);
        tbl[4]  = v(1, 1, 1, 0,      1, 32'hC,  I3,  1, 8'h04);
        tbl[5]  = v(1, 0, 0, 0,      0, 0,      0,   0, 8'h00);
        tbl[6]  = v(1, 0, 0, 0,      1, 0,      I0,  1, 8'h01);
        tbl[7]  = v(1, 0, 0, 0,      1, 0,      I0,  2, 8'h02);
        tbl[8]  = v(1, 0, 0, 0,      1, 0,      I0,  2, 8'h02);
        tbl[9]  = v(1, 0, 0, 0,      1, 0,      I0,  2, 8'h02);
        tbl[10] = v(1, 1, 0, 0,      1, 0,      I0,  2, 8'h02);
        tbl[11] = v(1, 1, 0, 0,      1, 4,      I1,  2, 8'h03);
        tbl[12] = v(1, 1, 1, 6,      1, 8,      I2,  2, 8'h04);
        tbl[13] = v(1, 1, 0, 0,      0, 0,      0,   0, 8'h01);
        tbl[14] = v(1, 1, 0, 0,      1, 4,      I1,  1, 8'h02);
        tbl[15] = v(1, 1, 1, 32'h3FC, 1, 8,     I2,  1, 8'h03);
        tbl[16] = v(1, 1, 0, 0,      0, 0,      0,   0, 8'hFF);
        tbl[17] = v(1, 1, 0, 0,      1, 32'h3FC, IFF, 1, 8'h00);
        tbl[18] = v(1, 1, 0, 0,      1, 32'h400, I0, 1, 8'h01);
        tbl[19] = v(0, 1, 0, 0,      1, 32'h404, I1, 1, 8'h02);
        tbl[20] = v(0, 1, 0, 0,      0, 0,      0,   0, 8'h02);
        tbl[21] = v(0, 1, 0, 0,      0, 0,      0,   0, 8'h02);
        tbl[22] = v(1, 1, 0, 0,      0, 0,      0,   0, 8'h02);
        tbl[23] = v(1, 1, 0, 0,      1, 32'h408, I2, 1, 8'h03);
        tbl[24] = v(1, 1, 0, 0,      0, 0,      0,   0, 8'h00);
        tbl[25] = v(1, 1, 0, 0,      1, 0,      I0,  1, 8'h01);
        tbl[26] = v(1, 1, 0, 0,      1, 4,      I1,  1, 8'h02);
        repeat (2) @(negedge clk);
        chk("reset_valid", -1, {31'd0, if_valid}, 32'd0);
        chk("reset_pc", -1, if_pc, 32'd0);
        chk("reset_inst", -1, if_inst, 32'd0);
        rst_n = 1;
        for (int i = 0; i < 27; i++) begin
            if (i == 24) mid_reset();
            step(i, tbl[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
